// File: rtl/data_array_param.sv
// One-hot addressed register-file data array with direct, multi-entry and delayed writers,
// optional write-to-read bypass and a saturating write-conflict counter.
module data_array_param #(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned NUM_READ    = 3,
    parameter int unsigned NUM_WRITE   = 2,
    parameter int unsigned NUM_MULTI   = 9,
    parameter int unsigned NUM_DELAYED = 2,
    parameter int unsigned BYPASS      = 1,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_READ*NUM_ENTRIES-1:0]     io_read_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]      io_read_data,
    input  logic [NUM_WRITE-1:0]                io_write_enable,
    input  logic [NUM_WRITE-1:0]                io_write_mask,
    input  logic [NUM_WRITE*NUM_ENTRIES-1:0]    io_write_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]     io_write_data,
    input  logic [NUM_MULTI-1:0]                io_multi_enable,
    input  logic [NUM_MULTI*NUM_ENTRIES-1:0]    io_multi_addr,
    input  logic [NUM_MULTI*DATA_WIDTH-1:0]     io_multi_data,
    input  logic [NUM_DELAYED-1:0]              io_delayed_mask,
    input  logic [NUM_DELAYED*NUM_ENTRIES-1:0]  io_delayed_addr,
    input  logic [NUM_DELAYED*DATA_WIDTH-1:0]   io_delayed_data,
    output logic                                io_conflict,
    output logic [CNT_WIDTH-1:0]                io_conflict_count
);

    logic [DATA_WIDTH-1:0]              mem_q [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]              mem_d [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]              wr_data [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]             wr_hit;
    logic [NUM_ENTRIES-1:0]             wr_multi;
    logic [NUM_DELAYED-1:0]             dly_valid_q;
    logic [NUM_DELAYED*NUM_ENTRIES-1:0] dly_addr_q;
    logic [NUM_DELAYED*DATA_WIDTH-1:0]  dly_data_q;
    logic                               conflict_d;
    logic                               conflict_q;
    logic [CNT_WIDTH-1:0]               count_d;
    logic [CNT_WIDTH-1:0]               count_q;

    // Writers are visited lowest to highest priority so the last hit wins.
    always_comb begin
        wr_hit   = '0;
        wr_multi = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            wr_data[e] = '0;
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (io_write_enable[w] && io_write_mask[w] && io_write_addr[w*NUM_ENTRIES+e]) begin
                    wr_multi[e] = wr_multi[e] | wr_hit[e];
                    wr_hit[e]   = 1'b1;
                    wr_data[e]  = io_write_data[w*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            for (int m = 0; m < NUM_MULTI; m++) begin
                if (io_multi_enable[m] && io_multi_addr[m*NUM_ENTRIES+e]) begin
                    wr_multi[e] = wr_multi[e] | wr_hit[e];
                    wr_hit[e]   = 1'b1;
                    wr_data[e]  = io_multi_data[m*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            for (int d = 0; d < NUM_DELAYED; d++) begin
                if (dly_valid_q[d] && dly_addr_q[d*NUM_ENTRIES+e]) begin
                    wr_multi[e] = wr_multi[e] | wr_hit[e];
                    wr_hit[e]   = 1'b1;
                    wr_data[e]  = dly_data_q[d*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            mem_d[e] = wr_hit[e] ? wr_data[e] : mem_q[e];
        end
        conflict_d = |wr_multi;
    end

    // Bypass reads see the post-edge value of each entry, i.e. the winning writer's data.
    always_comb begin
        io_read_data = '0;
        for (int r = 0; r < NUM_READ; r++) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                if (io_read_addr[r*NUM_ENTRIES+e]) begin
                    io_read_data[r*DATA_WIDTH +: DATA_WIDTH] |=
                        (BYPASS != 0) ? mem_d[e] : mem_q[e];
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (conflict_d && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                mem_q[e] <= '0;
            end
            dly_valid_q <= '0;
            dly_addr_q  <= '0;
            dly_data_q  <= '0;
            conflict_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                mem_q[e] <= mem_d[e];
            end
            dly_valid_q <= io_delayed_mask;
            dly_addr_q  <= io_delayed_addr;
            dly_data_q  <= io_delayed_data;
            conflict_q  <= conflict_d;
            count_q     <= count_d;
        end
    end

    assign io_conflict       = conflict_q;
    assign io_conflict_count = count_q;

endmodule

// File: doc/data_array_param.md
Name: data_array_param

Overview:
- Parametrised one-hot-addressed register-file data array for the issue/dispatch data path; successor to the fixed 16x64, 3-read/13-write data arrays.
- Provides combinational reads and same-cycle direct and multi-entry writes.
- Adds an internal delayed-write stage, optional write-to-read bypass, and write-conflict detection with a saturating counter.

Parameters:
NUM_ENTRIES, 16, number of entries; one-hot address vector width
DATA_WIDTH, 64, bits per entry
NUM_READ, 3, read ports
NUM_WRITE, 2, direct write ports (enable & mask)
NUM_MULTI, 9, multi-entry write ports (address vector may have several bits set)
NUM_DELAYED, 2, delayed write ports (registered internally, committed one cycle later)
BYPASS, 1, 1 = reads return same-cycle committing write data; 0 = reads return stored data
CNT_WIDTH, 16, conflict counter width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
io_read_addr  in  NUM_READ*NUM_ENTRIES  one-hot read vector per port (port r = slice r)
io_read_data  out  NUM_READ*DATA_WIDTH  read data per port
io_write_enable  in  NUM_WRITE  direct write enable
io_write_mask  in  NUM_WRITE  direct write mask; effective write = enable & mask
io_write_addr  in  NUM_WRITE*NUM_ENTRIES  one-hot write vector
io_write_data  in  NUM_WRITE*DATA_WIDTH  direct write data
io_multi_enable  in  NUM_MULTI  multi-write enable
io_multi_addr  in  NUM_MULTI*NUM_ENTRIES  entry vector, any number of bits set
io_multi_data  in  NUM_MULTI*DATA_WIDTH  multi-write data
io_delayed_mask  in  NUM_DELAYED  delayed write request
io_delayed_addr  in  NUM_DELAYED*NUM_ENTRIES  one-hot delayed write vector
io_delayed_data  in  NUM_DELAYED*DATA_WIDTH  delayed write data
io_conflict  out  1  registered pulse: a write conflict occurred in the previous cycle
io_conflict_count  out  CNT_WIDTH  saturating count of conflict cycles

Behaviour:
- Reset (sync): all entries = 0; delayed-stage valids = 0 (pending delayed writes dropped); io_conflict = 0; io_conflict_count = 0. Reset overrides all writes in the same cycle.
- Read: combinational, zero latency.
  - io_read_data[r] = OR of every entry whose bit is set in io_read_addr[r].
  - All-zero vector -> 0; multi-hot vector -> bitwise OR of the selected entries (defined, not an error).
- Delayed stage:
  - Cycle T: register {mask, addr, data} per delayed port.
  - Cycle T+1: stage acts as a committing writer with enable = registered mask.
  - Data is visible to a BYPASS=0 read in cycle T+2, and to a BYPASS=1 read in cycle T+1.
- Committing writers per cycle, in priority order lowest to highest: direct 0..NUM_WRITE-1, multi 0..NUM_MULTI-1, delayed stage 0..NUM_DELAYED-1. The highest-priority writer to an entry wins. Direct and delayed address vectors are one-hot; multi-hot on them writes all selected entries.
- Array update: on the rising edge, each entry takes the winning data; entries with no writer hold their value.
- Bypass:
  - BYPASS=1: a read of an entry with a committing writer returns that writer's data in the same cycle (the same winner as the array update).
  - BYPASS=0: a read returns the pre-edge stored value.
- Conflict: a cycle is a conflict cycle when any entry has ≥2 committing writers.
  - io_conflict <= conflict (1-cycle registered pulse).
  - io_conflict_count increments by 1 per conflict cycle and saturates at 2^CNT_WIDTH-1 without wrapping.
- No backpressure or handshake: every write is accepted every cycle.
- Width rules: no arithmetic on data; the counter is unsigned.

Test Plan:
- Reset, then read all entries on all ports -> every io_read_data = 0, io_conflict = 0, count = 0.
- Direct write 0: addr bit 3, data 0xDEAD_BEEF_0000_0001, enable=1, mask=1; read port 0 at bit 3 in the same cycle -> BYPASS=1: 0xDEAD_BEEF_0000_0001 same cycle; BYPASS=0: old value 0, new value next cycle. With mask=0 -> entry unchanged.
- Multi-write 4: addr 0x00F0, data 0x55 -> entries 4..7 all read 0x55 next cycle. Read with rvec 0x0030 -> 0x55.
- Delayed write 1: addr bit 9, data 0xA5 at T; direct write 0 to entry 9 with 0x11 at T+1 -> delayed stage wins, entry 9 = 0xA5 at T+2, io_conflict = 1 at T+2, count = 1.
- Delayed write at T, reset asserted at T+1 -> entry stays 0, no conflict recorded.
- CNT_WIDTH=2: 5 consecutive conflict cycles -> count sequence 1, 2, 3, 3, 3; io_conflict high for 5 cycles, then 0.
